// File: rtl/seq_det_pkg.sv
// Shared constants, types and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } ovl_mode_e;

  // Width needed to hold a pattern length of 0..max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with a sticky flag that sets once the count reaches all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (inc) begin
      if (cnt_q != {W{1'b1}}) begin
        cnt_d = cnt_q + W'(1);
      end
      sat_d = sat_q | (cnt_d == {W{1'b1}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial detector for a run-time programmable 1..MAX_LEN bit pattern with
// overlapping/non-overlapping modes, registered match pulse and saturating count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               X,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  output logic               Y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat,
  output logic               len_err
);

  logic [MAX_LEN-1:0] hist_q, hist_d, hist_sh;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_sh;
  logic               y_q, y_d;
  logic [MAX_LEN-1:0] diff;
  logic               match;

  assign len_err = (pat_len == '0) || (pat_len > LEN_W'(MAX_LEN));

  // Candidate history and fill level as they would be after taking X.
  assign hist_sh = {hist_q[MAX_LEN-2:0], X};
  assign fill_sh = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

  // Only the lowest pat_len positions take part in the compare.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
      assign diff[gi] = (pat_len > LEN_W'(gi)) && (hist_sh[gi] != pattern[gi]);
    end
  endgenerate

  assign match = en && !clr && !len_err && (fill_sh >= pat_len) && (diff == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = 1'b0;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = hist_sh;
      fill_d = fill_sh;
      y_d    = match;
      // Emptying the fill level keeps matched bits from seeding the next match.
      if (match && (ovl_mode_e'(overlap) == OVL_OFF)) begin
        fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (match),
    .cnt  (match_cnt),
    .sat  (cnt_sat)
  );

  assign Y = y_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: per-cycle check against a queue-based
// reference model plus hand-computed expectations for each scenario.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic             X;
  logic [MAX_LEN-1:0] pattern;
  logic [3:0]       pat_len;
  logic             overlap;
  logic             Y;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic             len_err;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  // Reference model state: bits received since the last reset/clear/consumed match.
  bit mq[$];
  int m_cnt = 0;
  bit m_sat = 0;
  bit m_y   = 0;

  logic [6:0] s7;
  logic [6:0] ey7;

  seq_detector_param #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .X        (X),
    .pattern  (pattern),
    .pat_len  (pat_len),
    .overlap  (overlap),
    .Y        (Y),
    .match_cnt(match_cnt),
    .cnt_sat  (cnt_sat),
    .len_err  (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit m;
    int pl;
    if (!rst_n) begin
      mq.delete();
      m_cnt = 0;
      m_sat = 0;
      m_y   = 0;
    end else if (clr) begin
      mq.delete();
      m_cnt = 0;
      m_sat = 0;
      m_y   = 0;
    end else if (!en) begin
      m_y = 0;
    end else begin
      mq.push_back(X);
      if (mq.size() > MAX_LEN) void'(mq.pop_front());
      pl = int'(pat_len);
      m  = 0;
      if (pl >= 1 && pl <= MAX_LEN && mq.size() >= pl) begin
        m = 1;
        for (int i = 0; i < pl; i++) begin
          if (mq[mq.size() - 1 - i] != pattern[i]) m = 0;
        end
      end
      m_y = m;
      if (m) begin
        m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
        if (m_cnt == CNT_MAX) m_sat = 1;
        if (!overlap) mq.delete();
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cmp_en) begin
        chk("model_y", int'(Y), int'(m_y));
        chk("model_cnt", int'(match_cnt), m_cnt);
        chk("model_sat", int'(cnt_sat), int'(m_sat));
        chk("model_lerr", int'(len_err), int'(pat_len == 0 || pat_len > MAX_LEN));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic x, input logic e);
    @(negedge clk);
    X   = x;
    en  = e;
    clr = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    #2;
    clr = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    clr     = 1'b0;
    X       = 1'b0;
    pattern = '0;
    pat_len = 4'd4;
    overlap = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_y", int'(Y), 0);
    chk("rst_cnt", int'(match_cnt), 0);
    chk("rst_sat", int'(cnt_sat), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Overlapping detection of 1101 in 1101101
    pattern = 8'b0000_1101;
    pat_len = 4'd4;
    overlap = 1'b1;
    s7  = 7'b1101101;
    ey7 = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      tick(s7[i], 1'b1);
      chk("ovl_y", int'(Y), int'(ey7[i]));
    end
    chk("ovl_cnt", int'(match_cnt), 2);
    do_clr();

    // Non-overlapping: the second occurrence shares bits with the first
    overlap = 1'b0;
    ey7 = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      tick(s7[i], 1'b1);
      chk("novl_y", int'(Y), int'(ey7[i]));
    end
    chk("novl_cnt", int'(match_cnt), 1);
    do_clr();

    // Enable gap between bits 2 and 3
    overlap = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      chk("gap_y", int'(Y), 0);
    end
    tick(1'b0, 1'b1);
    chk("gap_y3", int'(Y), 0);
    tick(1'b1, 1'b1);
    chk("gap_y4", int'(Y), 1);
    chk("gap_cnt", int'(match_cnt), 1);

    // Asynchronous reset mid-pattern
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    chk("prerst_cnt", int'(match_cnt), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_y", int'(Y), 0);
    chk("arst_cnt", int'(match_cnt), 0);
    chk("arst_sat", int'(cnt_sat), 0);
    rst_n = 1'b1;
    tick(1'b1, 1'b1);
    chk("postrst_y", int'(Y), 0);
    chk("postrst_cnt", int'(match_cnt), 0);

    // Same with synchronous clear
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    do_clr();
    tick(1'b1, 1'b1);
    chk("postclr_y", int'(Y), 0);
    chk("postclr_cnt", int'(match_cnt), 0);

    // Saturation with a single-bit pattern
    pattern = 8'b0000_0001;
    pat_len = 4'd1;
    overlap = 1'b1;
    do_clr();
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1, 1'b1);
      chk("sat_y", int'(Y), 1);
      chk("sat_cnt", int'(match_cnt), (k < CNT_MAX) ? k : CNT_MAX);
      chk("sat_flag", int'(cnt_sat), (k >= CNT_MAX) ? 1 : 0);
    end
    do_clr();
    chk("satclr_cnt", int'(match_cnt), 0);
    chk("satclr_flag", int'(cnt_sat), 0);

    // Length errors: zero and MAX_LEN+1
    pat_len = 4'd0;
    for (int i = 0; i < 25; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b1);
      chk("lerr0_flag", int'(len_err), 1);
      chk("lerr0_y", int'(Y), 0);
    end
    pat_len = 4'(MAX_LEN + 1);
    for (int i = 0; i < 25; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b1);
      chk("lerr9_flag", int'(len_err), 1);
      chk("lerr9_y", int'(Y), 0);
    end

    // Full-length all-zero pattern after clearing history
    pattern = '0;
    pat_len = 4'(MAX_LEN);
    do_clr();
    chk("full_lerr", int'(len_err), 0);
    for (int k = 1; k <= MAX_LEN; k++) begin
      tick(1'b0, 1'b1);
      chk("full_y", int'(Y), (k == MAX_LEN) ? 1 : 0);
    end
    chk("full_cnt", int'(match_cnt), 1);

    @(negedge clk);
    en     = 1'b0;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
